// File: rtl/dmem_access_ctrl.sv
// Memory-stage data access controller: turns the held EX/MEM load/store request into a
// one-shot memory handshake, stalls the pipeline until completion, and flags errors.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT     = 15,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [15:0] Addr_in,
  input  logic [15:0] WrData_in,
  input  logic        halt_in,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        DC_Stall,
  output logic [15:0] RdData_out,
  output logic        err_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;

  logic req;
  logic reqConflict;
  logic reqMisaligned;
  logic reqBad;

  assign req           = (MemRead_in | MemWrite_in) & ~halt_in;
  assign reqConflict   = MemRead_in & MemWrite_in;
  assign reqMisaligned = ALIGN_CHECK & Addr_in[0];
  assign reqBad        = reqConflict | reqMisaligned;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 16'd0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

  // The issued operation type is captured so completion does not depend on the held inputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (reqBad) begin
            state_d = ST_ERR;
          end else if (!mem_busy) begin
            state_d = ST_WAIT;
            cnt_d   = 8'd0;
            wr_d    = MemWrite_in;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_done) begin
          if (!wr_q) begin
            rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (cnt_d >= TIMEOUT_C) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_ERR) begin
      err_d = 1'b1;
    end
  end

  // Address and data pass straight through; EX/MEM keeps them stable while stalled.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    DC_Stall  = 1'b0;
    mem_addr  = Addr_in;
    mem_wdata = WrData_in;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (req && !reqBad) begin
            DC_Stall = 1'b1;
            if (!mem_busy) begin
              mem_en = 1'b1;
              mem_wr = MemWrite_in;
            end
          end
        end
        ST_WAIT: begin
          DC_Stall = 1'b1;
        end
        default: begin
          DC_Stall = 1'b0;
        end
      endcase
    end
  end

  assign RdData_out = rdata_q;
  assign err_out    = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: stimulus queues expected requests and completions,
// a negedge monitor compares them as the DUT presents mem_en strobes and stall releases.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [15:0] Addr_in;
  logic [15:0] WrData_in;
  logic        halt_in;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_busy;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        DC_Stall;
  logic [15:0] RdData_out;
  logic        err_out;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  typedef struct packed {
    logic [7:0]  stall;
    logic        err;
    logic [15:0] rd;
  } done_t;

  req_t  reqQ[$];
  done_t doneQ[$];
  int    numChecks;
  int    numFails;
  int    streak;

  dmem_access_ctrl #(.TIMEOUT(15), .ALIGN_CHECK(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead_in (MemRead_in),
    .MemWrite_in(MemWrite_in),
    .Addr_in    (Addr_in),
    .WrData_in  (WrData_in),
    .halt_in    (halt_in),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_busy   (mem_busy),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .DC_Stall   (DC_Stall),
    .RdData_out (RdData_out),
    .err_out    (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every mem_en strobe must match the next queued request, every stall release
  // must match the next queued completion (stall length, error flag, load data).
  always @(negedge clk) begin
    if (!rst) begin
      streak = 0;
    end else begin
      if (mem_en) begin
        if (reqQ.size() == 0) begin
          checkOutput("unexpected_mem_en", 32'(mem_en), 32'd0);
        end else begin
          req_t r;
          r = reqQ.pop_front();
          checkOutput("mem_wr", 32'(mem_wr), 32'(r.wr));
          checkOutput("mem_addr", 32'(mem_addr), 32'(r.addr));
          if (r.wr) checkOutput("mem_wdata", 32'(mem_wdata), 32'(r.wdata));
        end
      end
      if (DC_Stall) begin
        streak++;
      end else if (streak > 0) begin
        if (doneQ.size() == 0) begin
          checkOutput("unexpected_stall_release", 32'(streak), 32'd0);
        end else begin
          done_t d;
          d = doneQ.pop_front();
          checkOutput("stall_cycles", 32'(streak), 32'(d.stall));
          checkOutput("err_at_release", 32'(err_out), 32'(d.err));
          checkOutput("rddata_at_release", 32'(RdData_out), 32'(d.rd));
        end
        streak = 0;
      end
    end
  end

  task automatic doReset(input logic staleDone);
    rst         = 1'b0;
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
    halt_in     = 1'b0;
    mem_busy    = 1'b0;
    mem_done    = staleDone;
    mem_rdata   = 16'hCAFE;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_DC_Stall", 32'(DC_Stall), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_RdData", 32'(RdData_out), 32'd0);
    checkOutput("rst_err", 32'(err_out), 32'd0);
    tick();
    mem_done = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_DC_Stall", 32'(DC_Stall), 32'd0);
    checkOutput("post_rst_RdData", 32'(RdData_out), 32'd0);
    tick();
  endtask

  // One complete access: optional busy cycles, then mem_done doneDelay cycles after mem_en.
  task automatic applyStimulus(input logic isWr, input logic [15:0] addr, input logic [15:0] wdata,
                               input int busyCycles, input int doneDelay, input logic [15:0] rdata,
                               input logic [15:0] expRd);
    reqQ.push_back('{wr: isWr, addr: addr, wdata: wdata});
    doneQ.push_back('{stall: 8'(busyCycles + 1 + doneDelay), err: 1'b0, rd: expRd});
    MemRead_in  = ~isWr;
    MemWrite_in = isWr;
    Addr_in     = addr;
    WrData_in   = wdata;
    mem_busy    = (busyCycles > 0);
    for (int i = 0; i < busyCycles; i++) tick();
    mem_busy = 1'b0;
    tick();
    for (int i = 1; i < doneDelay; i++) tick();
    mem_done  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_done  = 1'b0;
    mem_rdata = 16'h0BAD;
    tick();
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
    tick();
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    streak    = 0;
    Addr_in   = 16'd0;
    WrData_in = 16'd0;
    doReset(1'b1);

    applyStimulus(1'b0, 16'h0010, 16'h0000, 0, 2, 16'hBEEF, 16'hBEEF);
    applyStimulus(1'b1, 16'h0020, 16'h1234, 0, 1, 16'hDEAD, 16'hBEEF);
    applyStimulus(1'b0, 16'h0040, 16'h0000, 3, 1, 16'h5A5A, 16'h5A5A);
    applyStimulus(1'b0, 16'h0100, 16'h0000, 0, 4, 16'h0F0F, 16'h0F0F);

    MemRead_in = 1'b1;
    halt_in    = 1'b1;
    Addr_in    = 16'h0200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("halt_DC_Stall", 32'(DC_Stall), 32'd0);
      tick();
    end
    halt_in    = 1'b0;
    MemRead_in = 1'b0;
    tick();

    MemRead_in  = 1'b1;
    MemWrite_in = 1'b1;
    Addr_in     = 16'h0002;
    @(negedge clk);
    checkOutput("conflict_DC_Stall", 32'(DC_Stall), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("conflict_err", 32'(err_out), 32'd1);
    doReset(1'b0);

    MemRead_in = 1'b1;
    Addr_in    = 16'h0021;
    @(negedge clk);
    checkOutput("align_DC_Stall", 32'(DC_Stall), 32'd0);
    checkOutput("align_err_same_cycle", 32'(err_out), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      checkOutput("align_err_sticky", 32'(err_out), 32'd1);
      checkOutput("align_DC_Stall_err", 32'(DC_Stall), 32'd0);
    end
    doReset(1'b0);

    reqQ.push_back('{wr: 1'b0, addr: 16'h0030, wdata: 16'h0000});
    doneQ.push_back('{stall: 8'd16, err: 1'b1, rd: 16'h0000});
    MemRead_in = 1'b1;
    Addr_in    = 16'h0030;
    for (int i = 0; i < 18; i++) tick();
    mem_done  = 1'b1;
    mem_rdata = 16'h9999;
    tick();
    mem_done = 1'b0;
    @(negedge clk);
    checkOutput("timeout_err_sticky", 32'(err_out), 32'd1);
    checkOutput("timeout_late_done_rd", 32'(RdData_out), 32'd0);
    checkOutput("timeout_DC_Stall", 32'(DC_Stall), 32'd0);
    doReset(1'b0);

    reqQ.push_back('{wr: 1'b0, addr: 16'h0050, wdata: 16'h0000});
    MemRead_in = 1'b1;
    Addr_in    = 16'h0050;
    tick();
    tick();
    rst        = 1'b0;
    MemRead_in = 1'b0;
    tick();
    rst       = 1'b1;
    mem_done  = 1'b1;
    mem_rdata = 16'h7777;
    @(negedge clk);
    checkOutput("abort_DC_Stall", 32'(DC_Stall), 32'd0);
    checkOutput("abort_err", 32'(err_out), 32'd0);
    tick();
    mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_RdData", 32'(RdData_out), 32'd0);
      checkOutput("abort_DC_Stall_idle", 32'(DC_Stall), 32'd0);
      tick();
    end

    applyStimulus(1'b0, 16'h0060, 16'h0000, 0, 1, 16'h1111, 16'h1111);

    tick();
    checkOutput("req_queue_drained", 32'(reqQ.size()), 32'd0);
    checkOutput("done_queue_drained", 32'(doneQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
